// File: rtl/rs_entry.sv
// One reservation-station slot: captures a dispatched instruction and snoops the CDB until its operands resolve.
// Provides a CDB bypass so that a slot can become ready in the same cycle as the broadcast.
package rs_entry_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [1:0]      opa_select;
        logic [3:0]      opb_select;
        logic [4:0]      dest_reg_idx;
        logic [4:0]      alu_func;
        logic            rd_mem;
        logic            wr_mem;
        logic            cond_branch;
        logic            halt;
        logic            illegal;
        logic            csr_op;
        logic            valid;
    } id_packet_t;

    typedef struct packed {
        logic [XLEN-1:0]  npc;
        logic [XLEN-1:0]  pc;
        logic [31:0]      inst;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
        logic [1:0]       opa_select;
        logic [3:0]       opb_select;
        logic [4:0]       dest_reg_idx;
        logic [4:0]       alu_func;
        logic             rd_mem;
        logic             wr_mem;
        logic             cond_branch;
        logic             halt;
        logic             illegal;
        logic             csr_op;
        logic             valid;
        logic [TAG_W-1:0] rob_tag;
    } is_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs1_ready;
        logic             rs2_ready;
    } mt2rs_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] reg_tag;
        logic [XLEN-1:0]  reg_value;
    } cdb_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] rob_entry;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
    } rob2rs_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rdy;
        logic [XLEN-1:0]  val;
    } operand_t;
endpackage

module rs_entry
    import rs_entry_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  id_packet_t     id_packet_in,
    input  mt2rs_packet_t  mt2rs_packet_in,
    input  cdb_packet_t    cdb_packet_in,
    input  rob2rs_packet_t rob2rs_packet_in,
    input  logic           clear,
    input  logic           wr_en,
    output is_packet_t     entry_packet,
    output logic           busy,
    output logic           ready
);

    id_packet_t       stored_id;
    logic [TAG_W-1:0] rob_tag;
    operand_t         op1;
    operand_t         op2;
    operand_t         new_op1;
    operand_t         new_op2;
    logic             hit1;
    logic             hit2;

    // Resolve an operand at dispatch: regfile, ROB, same-cycle CDB, or left waiting on its tag.
    function automatic operand_t dispatch_operand(
        input logic [TAG_W-1:0] tag,
        input logic             mt_ready,
        input logic [XLEN-1:0]  id_val,
        input logic [XLEN-1:0]  rob_val,
        input cdb_packet_t      cdb
    );
        operand_t op;
        op.tag = tag;
        op.rdy = 1'b1;
        op.val = id_val;
        if (tag == '0) begin
            op.val = id_val;
        end else if (mt_ready) begin
            op.val = rob_val;
        end else if (cdb.reg_tag == tag) begin
            op.val = cdb.reg_value;
        end else begin
            op.rdy = 1'b0;
        end
        return op;
    endfunction

    always_comb begin
        new_op1 = dispatch_operand(mt2rs_packet_in.rs1_tag, mt2rs_packet_in.rs1_ready,
                                   id_packet_in.rs1_value, rob2rs_packet_in.rs1_value, cdb_packet_in);
        new_op2 = dispatch_operand(mt2rs_packet_in.rs2_tag, mt2rs_packet_in.rs2_ready,
                                   id_packet_in.rs2_value, rob2rs_packet_in.rs2_value, cdb_packet_in);
    end

    // Only a waiting operand can hit; tag 0 is never a real broadcast.
    assign hit1 = busy && !op1.rdy && (cdb_packet_in.reg_tag != '0) && (cdb_packet_in.reg_tag == op1.tag);
    assign hit2 = busy && !op2.rdy && (cdb_packet_in.reg_tag != '0) && (cdb_packet_in.reg_tag == op2.tag);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            stored_id <= '0;
            rob_tag   <= '0;
            op1       <= '0;
            op2       <= '0;
        end else if (wr_en) begin
            busy      <= 1'b1;
            stored_id <= id_packet_in;
            rob_tag   <= rob2rs_packet_in.rob_entry;
            op1       <= new_op1;
            op2       <= new_op2;
        end else if (clear) begin
            busy      <= 1'b0;
            stored_id <= '0;
            rob_tag   <= '0;
            op1       <= '0;
            op2       <= '0;
        end else begin
            if (hit1) begin
                op1.val <= cdb_packet_in.reg_value;
                op1.rdy <= 1'b1;
            end
            if (hit2) begin
                op2.val <= cdb_packet_in.reg_value;
                op2.rdy <= 1'b1;
            end
        end
    end

    assign ready = busy && (op1.rdy || hit1) && (op2.rdy || hit2);

    always_comb begin
        entry_packet              = '0;
        entry_packet.npc          = stored_id.npc;
        entry_packet.pc           = stored_id.pc;
        entry_packet.inst         = stored_id.inst;
        entry_packet.rs1_value    = hit1 ? cdb_packet_in.reg_value : op1.val;
        entry_packet.rs2_value    = hit2 ? cdb_packet_in.reg_value : op2.val;
        entry_packet.opa_select   = stored_id.opa_select;
        entry_packet.opb_select   = stored_id.opb_select;
        entry_packet.dest_reg_idx = stored_id.dest_reg_idx;
        entry_packet.alu_func     = stored_id.alu_func;
        entry_packet.rd_mem       = stored_id.rd_mem;
        entry_packet.wr_mem       = stored_id.wr_mem;
        entry_packet.cond_branch  = stored_id.cond_branch;
        entry_packet.halt         = stored_id.halt;
        entry_packet.illegal      = stored_id.illegal;
        entry_packet.csr_op       = stored_id.csr_op;
        entry_packet.valid        = stored_id.valid;
        entry_packet.rob_tag      = rob_tag;
    end

endmodule

// File: tb/tb_rs_entry.sv
// Directed bench for one reservation-station slot: dispatch paths, CDB capture and bypass, clear and async reset.
module tb_rs_entry;
    import rs_entry_pkg::*;

    logic           clock;
    logic           reset;
    id_packet_t     id_packet_in;
    mt2rs_packet_t  mt2rs_packet_in;
    cdb_packet_t    cdb_packet_in;
    rob2rs_packet_t rob2rs_packet_in;
    logic           clear;
    logic           wr_en;
    is_packet_t     entry_packet;
    logic           busy;
    logic           ready;

    int passed = 0;
    int total  = 0;

    rs_entry dut (
        .clock            (clock),
        .reset            (reset),
        .id_packet_in     (id_packet_in),
        .mt2rs_packet_in  (mt2rs_packet_in),
        .cdb_packet_in    (cdb_packet_in),
        .rob2rs_packet_in (rob2rs_packet_in),
        .clear            (clear),
        .wr_en            (wr_en),
        .entry_packet     (entry_packet),
        .busy             (busy),
        .ready            (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_mt(input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                          input logic r1, input logic r2);
        mt2rs_packet_in.rs1_tag   = t1;
        mt2rs_packet_in.rs2_tag   = t2;
        mt2rs_packet_in.rs1_ready = r1;
        mt2rs_packet_in.rs2_ready = r2;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        cdb_packet_in.reg_tag   = t;
        cdb_packet_in.reg_value = v;
    endtask

    task automatic do_clear();
        wr_en = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        id_packet_in     = '0;
        mt2rs_packet_in  = '0;
        cdb_packet_in    = '0;
        rob2rs_packet_in = '0;
        clear            = 1'b0;
        wr_en            = 1'b0;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_pkt_zero", 32'(|entry_packet), 32'd0);
        reset = 1'b1;
        step();

        // 1: both operands from the regfile
        id_packet_in.inst      = 32'hABCDEF12;
        id_packet_in.pc        = 32'h0000_0100;
        id_packet_in.alu_func  = 5'd9;
        id_packet_in.valid     = 1'b1;
        id_packet_in.rs1_value = 32'd1;
        id_packet_in.rs2_value = 32'd1;
        set_mt(5'd0, 5'd0, 1'b0, 1'b0);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(ready), 32'd1);
        check("t1_rs1", entry_packet.rs1_value, 32'd1);
        check("t1_rs2", entry_packet.rs2_value, 32'd1);
        check("t1_inst", entry_packet.inst, 32'hABCDEF12);
        check("t1_pc", entry_packet.pc, 32'h0000_0100);
        check("t1_alu", 32'(entry_packet.alu_func), 32'd9);
        do_clear();
        check("t1_clr_busy", 32'(busy), 32'd0);
        check("t1_clr_ready", 32'(ready), 32'd0);
        check("t1_clr_inst", entry_packet.inst, 32'd0);

        // 2: operands from the ROB, write wins over clear
        set_mt(5'd1, 5'd1, 1'b1, 1'b1);
        rob2rs_packet_in.rob_entry = 5'd5;
        rob2rs_packet_in.rs1_value = 32'd16;
        rob2rs_packet_in.rs2_value = 32'd16;
        wr_en = 1'b1;
        clear = 1'b1;
        step();
        wr_en = 1'b0;
        clear = 1'b0;
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_ready", 32'(ready), 32'd1);
        check("t2_rs1", entry_packet.rs1_value, 32'd16);
        check("t2_rs2", entry_packet.rs2_value, 32'd16);
        check("t2_robtag", 32'(entry_packet.rob_tag), 32'd5);
        do_clear();

        // 3: rs1 waits on tag 2, rs2 from ROB
        id_packet_in.rs1_value     = 32'd7;
        id_packet_in.rs2_value     = 32'h55;
        rob2rs_packet_in.rs1_value = 32'h99;
        rob2rs_packet_in.rs2_value = 32'd0;
        set_mt(5'd2, 5'd3, 1'b0, 1'b1);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("t3_ready0", 32'(ready), 32'd0);
        check("t3_rs1_ph", entry_packet.rs1_value, 32'd7);
        check("t3_rs2", entry_packet.rs2_value, 32'd0);
        step();
        check("t3_idle_ready", 32'(ready), 32'd0);
        set_cdb(5'd2, 32'd10);
        #1;
        check("t3_byp_ready", 32'(ready), 32'd1);
        check("t3_byp_rs1", entry_packet.rs1_value, 32'd10);
        step();
        set_cdb(5'd0, 32'd0);
        #1;
        check("t3_lat_ready", 32'(ready), 32'd1);
        check("t3_lat_rs1", entry_packet.rs1_value, 32'd10);
        do_clear();

        // 4: both waiting, resolved by two broadcasts
        id_packet_in.rs1_value = 32'd8;
        id_packet_in.rs2_value = 32'd9;
        set_mt(5'd3, 5'd4, 1'b0, 1'b0);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("t4_wait_rs1", entry_packet.rs1_value, 32'd8);
        check("t4_wait_rs2", entry_packet.rs2_value, 32'd9);
        set_cdb(5'd4, 32'd10);
        step();
        set_cdb(5'd0, 32'd0);
        #1;
        check("t4_a_rs1", entry_packet.rs1_value, 32'd8);
        check("t4_a_rs2", entry_packet.rs2_value, 32'd10);
        check("t4_a_ready", 32'(ready), 32'd0);
        set_cdb(5'd3, 32'd10);
        step();
        set_cdb(5'd0, 32'd0);
        #1;
        check("t4_b_rs1", entry_packet.rs1_value, 32'd10);
        check("t4_b_rs2", entry_packet.rs2_value, 32'd10);
        check("t4_b_ready", 32'(ready), 32'd1);
        set_cdb(5'd4, 32'h77);
        #1;
        check("t4_ign_comb", entry_packet.rs2_value, 32'd10);
        step();
        set_cdb(5'd0, 32'd0);
        #1;
        check("t4_ign_lat", entry_packet.rs2_value, 32'd10);
        do_clear();
        check("t4_clr_ready", 32'(ready), 32'd0);

        // 5: rs1 from ROB, rs2 resolved by same-cycle bypass; tag 0 never matches
        id_packet_in.rs1_value     = 32'hA;
        id_packet_in.rs2_value     = 32'h3;
        rob2rs_packet_in.rs1_value = 32'hA;
        set_mt(5'd3, 5'd4, 1'b1, 1'b0);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("t5_ready0", 32'(ready), 32'd0);
        check("t5_rs1", entry_packet.rs1_value, 32'hA);
        set_cdb(5'd0, 32'h44);
        #1;
        check("t5_tag0_ready", 32'(ready), 32'd0);
        check("t5_tag0_rs2", entry_packet.rs2_value, 32'h3);
        set_cdb(5'd4, 32'd12);
        #1;
        check("t5_byp_ready", 32'(ready), 32'd1);
        check("t5_byp_rs2", entry_packet.rs2_value, 32'd12);
        set_cdb(5'd0, 32'd0);
        do_clear();

        // 6: capture from the CDB at dispatch, then async reset while busy and waiting
        id_packet_in.rs1_value = 32'h1;
        id_packet_in.rs2_value = 32'h2;
        set_mt(5'd6, 5'd7, 1'b0, 1'b0);
        set_cdb(5'd6, 32'h21);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        set_cdb(5'd0, 32'd0);
        #1;
        check("t6_wr_cdb_rs1", entry_packet.rs1_value, 32'h21);
        check("t6_wr_busy", 32'(busy), 32'd1);
        check("t6_wr_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ready", 32'(ready), 32'd0);
        check("t6_rst_pkt_zero", 32'(|entry_packet), 32'd0);
        reset = 1'b1;
        step();

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
